// File: rtl/channel_window_averager.sv
// Per-channel running window sum and floor(sum/10) average, two-stage valid/ready pipeline.
// Optional feature macro: CHANNEL_CLEAR_EN (adds clr_valid/clr_ch per-channel clear).
module channel_window_averager #(
  parameter int NUM_CHANNELS = 7,
  parameter int SAMPLE_BITS  = 8,
  parameter int WINDOW       = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_ch,
  input  logic [SAMPLE_BITS-1:0] in_new,
  input  logic [SAMPLE_BITS-1:0] in_old,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_ch,
  output logic [11:0]            out_sum,
  output logic [7:0]             out_avg,
  output logic                   out_warm,
  output logic                   err
`ifdef CHANNEL_CLEAR_EN
  ,
  input  logic                   clr_valid,
  input  logic [2:0]             clr_ch
`endif
);

  localparam logic [3:0] NUM_CH = 4'(NUM_CHANNELS);
  localparam logic [3:0] WIN    = 4'(WINDOW);

  // Storage covers the full 3-bit index space; entries at or above NUM_CHANNELS are never written.
  logic [11:0] sum_q  [8];
  logic [3:0]  fill_q [8];

  logic        a_valid;
  logic [2:0]  a_ch;
  logic [11:0] a_sum;
  logic        a_warm;

  logic        legal;
  logic        cur_warm;
  logic [11:0] cur_sum;
  logic [3:0]  cur_fill;
  logic [SAMPLE_BITS-1:0] old_eff;
  logic [12:0] next_sum;
  logic        underflow;
  logic [11:0] new_sum;
  logic [3:0]  new_fill;
  logic        b_load;
  logic        accept;
  logic        clr_active;

`ifdef CHANNEL_CLEAR_EN
  assign clr_active = clr_valid;
`else
  assign clr_active = 1'b0;
`endif

  assign legal     = {1'b0, in_ch} < NUM_CH;
  assign cur_sum   = sum_q[in_ch];
  assign cur_fill  = fill_q[in_ch];
  assign cur_warm  = (cur_fill == WIN);
  // Evicted samples are stale buffer contents until the window has filled once.
  assign old_eff   = cur_warm ? in_old : '0;
  assign next_sum  = 13'(cur_sum) + 13'(in_new) - 13'(old_eff);
  assign underflow = next_sum[12];
  assign new_sum   = underflow ? 12'd0 : next_sum[11:0];
  assign new_fill  = cur_warm ? WIN : cur_fill + 4'd1;

  assign b_load   = !out_valid || out_ready;
  assign in_ready = !reset && (!a_valid || b_load) && !clr_active;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        sum_q[i]  <= '0;
        fill_q[i] <= '0;
      end
      a_valid   <= 1'b0;
      a_ch      <= '0;
      a_sum     <= '0;
      a_warm    <= 1'b0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sum   <= '0;
      out_avg   <= '0;
      out_warm  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= accept && (!legal || underflow);

`ifdef CHANNEL_CLEAR_EN
      if (clr_valid && ({1'b0, clr_ch} < NUM_CH)) begin
        sum_q[clr_ch]  <= '0;
        fill_q[clr_ch] <= '0;
      end
`endif

      if (accept && legal) begin
        sum_q[in_ch]  <= new_sum;
        fill_q[in_ch] <= new_fill;
      end

      // Stage A refills on an accept; otherwise it empties when its result moves into B.
      if (accept) begin
        a_valid <= legal;
        if (legal) begin
          a_ch   <= in_ch;
          a_sum  <= new_sum;
          a_warm <= cur_warm;
        end
      end else if (b_load) begin
        a_valid <= 1'b0;
      end

      if (b_load) begin
        out_valid <= a_valid;
        if (a_valid) begin
          out_ch   <= a_ch;
          out_sum  <= a_sum;
          // Reciprocal multiply; exact floor(/10) over the 0..2550 reachable range.
          out_avg  <= 8'(({13'd0, a_sum} * 25'd6554) >> 16);
          out_warm <= a_warm;
        end
      end
    end
  end

endmodule

// File: doc/channel_window_averager.md
# channel_window_averager

Downstream consumer of the per-channel 10-sample shift buffer. For every sample the buffer accepts, this block receives the channel index, the new sample and the sample evicted from that channel's window. It keeps a running 12-bit window sum per channel and emits the sum and the window average (sum/10) through a valid/ready output port. It is a two-stage pipeline with full-throughput backpressure.

## Interface
- NUM_CHANNELS, 7, number of channels; legal range 1..8.
- SAMPLE_BITS, 8, sample width. Fixed: the divide constant is sized for 8-bit samples and a window of 10.
- WINDOW, 10, samples per window. Fixed at 10; fill counters saturate at this value.

Ports (reset is asynchronous and active-high, named as the codebase does):
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample offered.
- in_ready  out  1  block can accept this cycle.
- in_ch  in  3  channel index.
- in_new  in  8  sample entering the window.
- in_old  in  8  sample leaving the window.
- out_valid  out  1  result held on out_*.
- out_ready  in  1  downstream accepts the result.
- out_ch  out  3  channel of the result.
- out_sum  out  12  window sum after the update.
- out_avg  out  8  floor(out_sum/10).
- out_warm  out  1  channel window was full (10 samples) at this update.
- err  out  1  one-cycle pulse on an illegal channel or an underflow clamp.
- clr_valid  in  1  clear request. Present only with CHANNEL_CLEAR_EN.
- clr_ch  in  3  channel to clear. Present only with CHANNEL_CLEAR_EN.

## Operation
- State per channel:
  - sum[ch]: 12 bits.
  - fill[ch]: 4 bits, saturating at 10.
- Accept: in_valid && in_ready at a rising edge.
- Stage A (at the accept edge). Read-modify-write happens in the same edge, so back-to-back samples on the same channel need no forwarding.
  - old_eff = (fill[ch] < 10) ? 0 : in_old. The stale buffer contents are masked during warm-up.
  - sum[ch] <= sum[ch] + in_new - old_eff, computed at 13 bits.
  - If the 13-bit result is negative: clamp to 0 and pulse err.
  - fill[ch] <= min(fill[ch]+1, 10).
  - Stage register captures ch, the new sum, and warm = (fill[ch] == 10) before the increment.
- Stage B:
  - out_sum <= A_sum.
  - out_avg <= (A_sum * 6554) >> 16. This is exact floor(/10) for 0..2550.
  - out_ch and out_warm are copied from stage A.
- Illegal channel (in_ch >= NUM_CHANNELS):
  - The sample is accepted and dropped.
  - No state changes and no output is produced.
  - err pulses one cycle after the accept edge.
- Flow control:
  - B loads when B is empty or out_ready is high.
  - A advances when B loads.
  - in_ready = !reset && (!A_valid || !out_valid || out_ready).
- Reset (asynchronous):
  - All sum and fill entries are 0.
  - A_valid, out_valid and err are 0.
  - out_ch, out_sum, out_avg and out_warm are 0.
  - in_ready is 0 while reset is asserted and 1 on the first cycle after release.
- Reset mid-operation: in-flight results are discarded. No output appears after reset is released until a new accept.

## Timing
- Latency: a sample accepted at edge N drives out_valid high after edge N+1.
- Throughput: one sample per cycle while out_ready is held high.
- Stall: with out_valid high and out_ready low, out_* stay stable and stage A holds.
  - If A_valid is also high, in_ready is low.
  - Recovery occurs in the same cycle out_ready rises; there is no bubble.
- out_valid stays high until accepted. It never drops without out_ready being high.
- err is registered and is high for exactly one cycle per event.

## Configuration
- CHANNEL_CLEAR_EN defined:
  - Adds clr_valid and clr_ch.
  - At an edge with clr_valid high, sum[clr_ch] and fill[clr_ch] are set to 0.
  - in_ready is forced low in that cycle, so a clear and an accept never coincide. The clear has priority.
  - A clear does not affect results already in stage A or stage B.
  - An illegal clr_ch is ignored without err.
- CHANNEL_CLEAR_EN undefined:
  - The ports are absent.
  - Channels are zeroed only by reset.

## Test plan
- Warm-up: feed ch 2 with in_new = 100 and in_old = 55 (garbage) 10 times.
  - out_sum goes 100, 200, …, 1000; out_avg goes 10…100.
  - out_warm is 0 for the first 10 results.
  - 11th sample (new = 40, old = 100): out_sum = 940, out_avg = 94, out_warm = 1.
- Full scale: warm ch 0 with ten samples of 255.
  - out_sum = 2550, out_avg = 255.
  - Then new = 0, old = 255: sum = 2295, avg = 229.
- Backpressure: stream 5 samples round-robin over ch 0..4 with out_ready low for 3 cycles mid-stream.
  - No result is lost or duplicated; order is preserved; out_* are stable while stalled.
  - in_ready drops only when both stages are full.
- Error paths:
  - in_ch = 7: err pulses once, no output, all sums unchanged.
  - Warmed ch 1 with sum 0, then new = 0, old = 9: sum clamps to 0 and err pulses.
- Reset: assert reset while 2 results are in flight.
  - out_valid = 0 immediately; the next sample on any channel yields out_sum = in_new with out_warm = 0.
- CHANNEL_CLEAR_EN: clear ch 3 after warm-up while in_valid is high.
  - in_ready is low that cycle.
  - The next ch 3 sample restarts from sum = in_new, fill = 1.
